// File: rtl/sb_bus_pkg.sv
// Shared system-bus definitions: field widths and the memory slave FSM encoding.
package sb_bus_pkg;

  localparam int unsigned SB_BURST_W = 8;
  localparam int unsigned SB_DATA_W  = 32;
  localparam int unsigned SB_BE_W    = 4;
  localparam int unsigned SB_WAIT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_DATA,
    ST_RD_END,
    ST_WR_DATA,
    ST_ERR
  } sb_state_e;

endpackage

// File: rtl/sb_mem_ram.sv
// Single-port synchronous RAM, 2**ADDR_WIDTH words, per-byte write enable, 1-cycle read latency.
module sb_mem_ram
  import sb_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic [SB_BE_W-1:0]    be,
  input  logic [SB_DATA_W-1:0]  wdata,
  output logic [SB_DATA_W-1:0]  rdata
);

  logic [SB_DATA_W-1:0] mem [2**ADDR_WIDTH];

  // NOTE: the array and its read register carry no reset, so this maps onto block RAM;
  // the read data is only ever consumed through a reset-cleared valid flag.
  always_ff @(posedge clk) begin
    for (int b = 0; b < SB_BE_W; b++) begin
      if (we && be[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sb_mem_slave.sv
// RAM-backed system-bus slave: single/burst reads and writes inside a BASE_ADDR window,
// with out-of-range bursts answered by a one-cycle error strobe.
module sb_mem_slave
  import sb_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned READ_WAIT  = 2,
  parameter int unsigned WRITE_WAIT = 3
) (
  input  logic                  sb_clock_i,
  input  logic                  sb_reset_n_i,
  input  logic                  sb_begin_transaction_i,
  input  logic [SB_DATA_W-1:0]  sb_address_data_i,
  input  logic                  sb_read_n_write_i,
  input  logic [SB_BE_W-1:0]    sb_byte_enables_i,
  input  logic [SB_BURST_W-1:0] sb_burst_size_i,
  input  logic                  sb_data_valid_i,
  input  logic                  sb_end_transaction_i,
  output logic [SB_DATA_W-1:0]  sb_address_data_o,
  output logic                  sb_data_valid_o,
  output logic                  sb_end_transaction_o,
  output logic                  sb_busy_o,
  output logic                  sb_error_o
);

  localparam int unsigned WIN_LSB = ADDR_WIDTH + 2;
  localparam logic [SB_WAIT_W-1:0] RD_WAIT_LOAD =
    (READ_WAIT >= 2) ? SB_WAIT_W'(READ_WAIT - 2) : '0;
  localparam logic [SB_WAIT_W-1:0] WR_WAIT_LOAD = SB_WAIT_W'(WRITE_WAIT);
  localparam logic [ADDR_WIDTH:0]  LAST_WORD    = (ADDR_WIDTH+1)'(2**ADDR_WIDTH - 1);

  sb_state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [SB_BURST_W-1:0]    cnt_q, cnt_d;
  logic [SB_BURST_W:0]      beats_q, beats_d;
  logic [SB_WAIT_W-1:0]     wait_q, wait_d;
  logic [SB_BE_W-1:0]       be_q, be_d;
  logic                     valid_q, valid_d;
  logic                     end_q, end_d;
  logic                     busy_q, busy_d;
  logic                     err_q, err_d;

  logic [ADDR_WIDTH-1:0]    word_in;
  logic [ADDR_WIDTH:0]      last_beat_word;
  logic                     sel, range_err, wr_accept;
  logic [ADDR_WIDTH-1:0]    ram_addr;
  logic [SB_DATA_W-1:0]     ram_rdata;

  assign word_in        = sb_address_data_i[WIN_LSB-1:2];
  assign sel            = sb_begin_transaction_i &&
                          (sb_address_data_i[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
  // Widened by one bit so a burst running off the top of the window cannot wrap.
  assign last_beat_word = (ADDR_WIDTH+1)'(word_in) + (ADDR_WIDTH+1)'(sb_burst_size_i);
  assign range_err      = last_beat_word > LAST_WORD;
  assign wr_accept      = (state_q == ST_WR_DATA) && sb_data_valid_i && !busy_q &&
                          (beats_q <= {1'b0, cnt_q});

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sb_clock_i or negedge sb_reset_n_i) begin
    if (!sb_reset_n_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      beats_q <= '0;
      wait_q  <= '0;
      be_q    <= '0;
      valid_q <= 1'b0;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      beats_q <= beats_d;
      wait_q  <= wait_d;
      be_q    <= be_d;
      valid_q <= valid_d;
      end_q   <= end_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    beats_d = beats_q;
    wait_d  = wait_q;
    be_d    = be_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sel) begin
          addr_d  = word_in;
          cnt_d   = sb_burst_size_i;
          be_d    = sb_byte_enables_i;
          beats_d = '0;
          if (range_err) begin
            state_d = ST_ERR;
          end else if (sb_read_n_write_i) begin
            state_d = (READ_WAIT <= 1) ? ST_RD_DATA : ST_RD_WAIT;
            wait_d  = RD_WAIT_LOAD;
          end else begin
            state_d = ST_WR_DATA;
            wait_d  = WR_WAIT_LOAD;
          end
        end
      end
      ST_RD_WAIT: begin
        if (sb_end_transaction_i || err_q) begin
          state_d = ST_IDLE;
        end else if (wait_q == '0) begin
          state_d = ST_RD_DATA;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      ST_RD_DATA: begin
        if (sb_end_transaction_i || err_q) begin
          state_d = ST_IDLE;
        end else begin
          beats_d = beats_q + 1'b1;
          state_d = (beats_q == {1'b0, cnt_q}) ? ST_RD_END : ST_RD_DATA;
        end
      end
      ST_RD_END: state_d = ST_IDLE;
      ST_WR_DATA: begin
        if (wait_q != '0) begin
          wait_d = wait_q - 1'b1;
        end
        if (wr_accept) begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          beats_d = beats_q + 1'b1;
        end
        if (sb_end_transaction_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // The RAM reads one cycle ahead: whenever a beat is due next cycle, advance the pointer now.
    if (state_d == ST_RD_DATA) begin
      addr_d = addr_d + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    valid_d = (state_d == ST_RD_DATA);
    end_d   = (state_d == ST_RD_END);
    err_d   = (state_d == ST_ERR);
    busy_d  = (state_d == ST_WR_DATA) && (wait_d != '0);
  end

  assign ram_addr = (state_q == ST_IDLE) ? word_in : addr_q;

  sb_mem_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (sb_clock_i),
    .addr  (ram_addr),
    .we    (wr_accept),
    .be    (be_q),
    .wdata (sb_address_data_i),
    .rdata (ram_rdata)
  );

  assign sb_address_data_o    = valid_q ? ram_rdata : '0;
  assign sb_data_valid_o      = valid_q;
  assign sb_end_transaction_o = end_q;
  assign sb_busy_o            = busy_q;
  assign sb_error_o           = err_q;

endmodule

// File: tb/tb_sb_mem_slave.sv
// Directed bench for sb_mem_slave: a table of single-beat accesses plus hand-written
// burst, busy-gating, overrun, abort and reset-mid-read sequences.
module tb_sb_mem_slave;

  logic        clk;
  logic        rst_n;
  logic        begin_i;
  logic [31:0] ad_i;
  logic        rnw_i;
  logic [3:0]  be_i;
  logic [7:0]  burst_i;
  logic        dv_i;
  logic        end_i;
  logic [31:0] ad_o;
  logic        dv_o;
  logic        end_o;
  logic        busy_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  logic        log_dv   [0:15];
  logic [31:0] log_data [0:15];
  logic        log_end  [0:15];
  logic        log_err  [0:15];
  logic [31:0] wbuf     [0:7];
  logic        busy1, err1;

  typedef struct {
    logic        rnw;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [7:0]  burst;
    logic [31:0] wdata;
    logic        exp_err;
    logic        exp_resp;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [16];

  sb_mem_slave #(
    .BASE_ADDR  (32'h0000_1000),
    .ADDR_WIDTH (10),
    .READ_WAIT  (2),
    .WRITE_WAIT (3)
  ) dut (
    .sb_clock_i             (clk),
    .sb_reset_n_i           (rst_n),
    .sb_begin_transaction_i (begin_i),
    .sb_address_data_i      (ad_i),
    .sb_read_n_write_i      (rnw_i),
    .sb_byte_enables_i      (be_i),
    .sb_burst_size_i        (burst_i),
    .sb_data_valid_i        (dv_i),
    .sb_end_transaction_i   (end_i),
    .sb_address_data_o      (ad_o),
    .sb_data_valid_o        (dv_o),
    .sb_end_transaction_o   (end_o),
    .sb_busy_o              (busy_o),
    .sb_error_o             (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives begin during cycle 0; returns 1ns into cycle 1.
  task automatic start(input logic [31:0] addr, input logic rnw, input logic [3:0] be,
                       input logic [7:0] burst);
    @(posedge clk); #1;
    begin_i = 1'b1; ad_i = addr; rnw_i = rnw; be_i = be; burst_i = burst;
    @(posedge clk); #1;
    begin_i = 1'b0; ad_i = '0; rnw_i = 1'b0; be_i = '0; burst_i = '0;
  endtask

  task automatic read_op(input logic [31:0] addr, input logic [7:0] burst, input int ncyc);
    start(addr, 1'b1, 4'hF, burst);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      log_dv[k]   = dv_o;
      log_data[k] = ad_o;
      log_end[k]  = end_o;
      log_err[k]  = err_o;
    end
  endtask

  // Beats come from wbuf; the end strobe rides on the last beat.
  task automatic write_op(input logic [31:0] addr, input logic [3:0] be,
                          input logic [7:0] burst, input int nbeats);
    start(addr, 1'b0, be, burst);
    busy1 = busy_o;
    err1  = err_o;
    for (int i = 0; i < nbeats; i++) begin
      int guard;
      guard = 0;
      while (busy_o === 1'b1 && guard < 16) begin
        @(posedge clk); #1;
        guard++;
      end
      check("busy_release", busy_o, 1'b0);
      dv_i = 1'b1; ad_i = wbuf[i]; end_i = (i == nbeats - 1);
      @(posedge clk); #1;
      dv_i = 1'b0; ad_i = '0; end_i = 1'b0;
    end
  endtask

  task automatic read_word(input string name, input logic [31:0] addr, input logic [31:0] exp);
    read_op(addr, 8'd0, 4);
    check(name, {log_dv[2], log_data[2]}, {1'b1, exp});
  endtask

  initial begin
    rst_n = 1'b0; begin_i = 1'b0; ad_i = '0; rnw_i = 1'b0; be_i = '0; burst_i = '0;
    dv_i = 1'b0; end_i = 1'b0;

    vecs[0]  = '{1'b0, 32'h0000_1000, 4'hF, 8'd0,  32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0};
    vecs[1]  = '{1'b1, 32'h0000_1000, 4'hF, 8'd0,  32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 32'h0000_1FFC, 4'hF, 8'd0,  32'h0BAD_F00D, 1'b0, 1'b1, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_1FFC, 4'hF, 8'd0,  32'h0,         1'b0, 1'b1, 32'h0BAD_F00D};
    vecs[4]  = '{1'b1, 32'h0000_1FFC, 4'hF, 8'd1,  32'h0,         1'b1, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 32'h0000_2000, 4'hF, 8'd0,  32'h0,         1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 32'h0000_0FFC, 4'hF, 8'd0,  32'h0,         1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_1023, 4'hF, 8'd0,  32'h5A5A_5A5A, 1'b0, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_3020, 4'hF, 8'd0,  32'hCAFE_BABE, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 32'h0000_1022, 4'hF, 8'd0,  32'h0,         1'b0, 1'b1, 32'h5A5A_5A5A};
    vecs[10] = '{1'b0, 32'h0000_1040, 4'hF, 8'd0,  32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 32'h0000_1054, 4'hF, 8'd0,  32'h0000_9999, 1'b0, 1'b1, 32'h0};
    vecs[12] = '{1'b1, 32'h0000_1F00, 4'hF, 8'd64, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 32'h0000_1FFC, 4'hF, 8'd1,  32'h1234_5678, 1'b1, 1'b0, 32'h0};
    vecs[14] = '{1'b1, 32'h0000_1FFC, 4'hF, 8'd0,  32'h0,         1'b0, 1'b1, 32'h0BAD_F00D};
    vecs[15] = '{1'b1, 32'h0000_1FF8, 4'hF, 8'd0,  32'h0,         1'b0, 1'b1, 32'h0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {ad_o, dv_o, end_o, busy_o, err_o}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].rnw) begin
        read_op(vecs[i].addr, vecs[i].burst, 4);
        check($sformatf("v%0d_err_c1", i), log_err[1], vecs[i].exp_err);
        check($sformatf("v%0d_err_c2", i), log_err[2], 1'b0);
        check($sformatf("v%0d_dv_c1", i), log_dv[1], 1'b0);
        check($sformatf("v%0d_dv_c2", i), log_dv[2], vecs[i].exp_resp);
        check($sformatf("v%0d_data_c2", i), log_data[2], vecs[i].exp_data);
        check($sformatf("v%0d_end_c3", i), log_end[3], vecs[i].exp_resp);
        check($sformatf("v%0d_idle_c4", i), {log_dv[4], log_end[4], log_err[4]}, 3'b000);
      end else begin
        wbuf[0] = vecs[i].wdata;
        write_op(vecs[i].addr, vecs[i].be, vecs[i].burst, 1);
        check($sformatf("v%0d_busy_c1", i), busy1, vecs[i].exp_resp);
        check($sformatf("v%0d_err_c1", i), err1, vecs[i].exp_err);
      end
    end

    // Burst write 1..4 at 0x1004, then burst read of 4 beats back.
    wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3; wbuf[3] = 32'd4;
    write_op(32'h0000_1004, 4'hF, 8'd3, 4);
    read_op(32'h0000_1004, 8'd3, 7);
    check("burst_dv_c1", log_dv[1], 1'b0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("burst_beat%0d", k), {log_dv[k+2], log_end[k+2], log_data[k+2]},
            {1'b1, 1'b0, 32'(k + 1)});
    end
    check("burst_end_c6", {log_dv[6], log_end[6]}, 2'b01);
    check("burst_idle_c7", {log_dv[7], log_end[7]}, 2'b00);

    // Byte-lane write over 0xFFFFFFFF with data_valid held high throughout the busy window.
    start(32'h0000_1040, 1'b0, 4'b0011, 8'd0);
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("be_busy_c%0d", k), busy_o, 1'b1);
      dv_i = 1'b1; ad_i = 32'h1234_5678;
      @(posedge clk); #1;
    end
    check("be_busy_c4", busy_o, 1'b0);
    dv_i = 1'b1; ad_i = 32'hAAAA_5555; end_i = 1'b1;
    @(posedge clk); #1;
    dv_i = 1'b0; ad_i = '0; end_i = 1'b0;
    read_word("be_readback", 32'h0000_1040, 32'hFFFF_5555);

    // A second beat on a single-beat write is dropped; the next word keeps its value.
    wbuf[0] = 32'h0000_1111; wbuf[1] = 32'h0000_2222;
    write_op(32'h0000_1050, 4'hF, 8'd0, 2);
    read_word("overrun_word0", 32'h0000_1050, 32'h0000_1111);
    read_word("overrun_word1", 32'h0000_1054, 32'h0000_9999);

    // Master end strobe during the first read beat aborts the burst.
    start(32'h0000_1004, 1'b1, 4'hF, 8'd3);
    @(negedge clk);
    @(negedge clk);
    check("abort_beat0", {dv_o, ad_o}, {1'b1, 32'd1});
    end_i = 1'b1;
    @(negedge clk);
    end_i = 1'b0;
    check("abort_quiet", {dv_o, end_o, ad_o}, '0);
    @(negedge clk);
    check("abort_idle", {dv_o, end_o, ad_o}, '0);

    // Reset during beat 2 of a 4-beat read.
    start(32'h0000_1004, 1'b1, 4'hF, 8'd3);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rst_beat2_before", {dv_o, ad_o}, {1'b1, 32'd2});
    rst_n = 1'b0;
    #1;
    check("rst_outputs_now", {ad_o, dv_o, end_o, busy_o, err_o}, '0);
    @(negedge clk);
    check("rst_outputs_held", {ad_o, dv_o, end_o, busy_o, err_o}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_outputs_after", {ad_o, dv_o, end_o, busy_o, err_o}, '0);
    read_word("rst_readback", 32'h0000_1004, 32'd1);
    read_word("rst_readback_last", 32'h0000_1010, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
